// File: rtl/xip_line_fetch_arbiter.sv
// XIP line-fetch arbiter: shares one QSPI line reader
// between the I-cache (port 0) and D-cache (port 1).
module xip_line_fetch_arbiter #(
  parameter int LINE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic [23:0]            addr0,
  output logic                   ack0,
  input  logic                   req1,
  input  logic [23:0]            addr1,
  output logic                   ack1,
  output logic                   fr_rd,
  output logic [23:0]            fr_addr,
  input  logic                   fr_done,
  input  logic [LINE_SIZE*8-1:0] fr_line,
  output logic                   line_wr,
  output logic [23:0]            line_addr,
  output logic [LINE_SIZE*8-1:0] line_data,
  output logic                   busy
);

  localparam logic [23:0] MASK =
    ~(24'(LINE_SIZE) - 24'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic        prio;
  logic        win_id;
  logic        pick;
  logic [23:0] pick_addr;
  logic        same0;
  logic        same1;
  logic        ack0_nxt;
  logic        ack1_nxt;

  // Round-robin pick: prio only matters when both ports miss
  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (req0 && req1):  pick = prio;
      (req1 && !req0): pick = 1'b1;
      (req0 && !req1): pick = 1'b0;
      default:         pick = 1'b0;
    endcase
  end

  assign pick_addr = pick ? addr1 : addr0;

  // Line-match of each port against the fetch in flight
  assign same0 = (addr0 & MASK) == fr_addr;
  assign same1 = (addr1 & MASK) == fr_addr;

  // Acks: winner if still asking, loser if it hits the same line
  always_comb begin
    ack0_nxt = 1'b0;
    ack1_nxt = 1'b0;
    if (win_id) begin
      ack1_nxt = req1;
      ack0_nxt = req0 && same0;
    end else begin
      ack0_nxt = req0;
      ack1_nxt = req1 && same1;
    end
  end

  // Fetch FSM with all strobes registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prio      <= 1'b0;
      win_id    <= 1'b0;
      fr_rd     <= 1'b0;
      fr_addr   <= '0;
      line_wr   <= 1'b0;
      line_addr <= '0;
      line_data <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            win_id  <= pick;
            fr_addr <= pick_addr & MASK;
            fr_rd   <= 1'b1;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          fr_rd <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fr_done) begin
            line_data <= fr_line;
            line_addr <= fr_addr;
            line_wr   <= 1'b1;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          line_wr <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          prio    <= ~win_id;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          fr_rd   <= 1'b0;
          line_wr <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xip_line_fetch_arbiter.sv
// Directed bench for xip_line_fetch_arbiter:
// vector table of fetches plus hand-written corner sequences.
module tb_xip_line_fetch_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0, req1;
  logic [23:0]  addr0, addr1;
  logic         ack0, ack1;
  logic         fr_rd;
  logic [23:0]  fr_addr;
  logic         fr_done;
  logic [127:0] fr_line;
  logic         line_wr;
  logic [23:0]  line_addr;
  logic [127:0] line_data;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int frd_cnt = 0;
  int lw_cnt = 0;
  int exp_frd = 0;
  int exp_lw = 0;

  xip_line_fetch_arbiter #(.LINE_SIZE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .addr0     (addr0),
    .ack0      (ack0),
    .req1      (req1),
    .addr1     (addr1),
    .ack1      (ack1),
    .fr_rd     (fr_rd),
    .fr_addr   (fr_addr),
    .fr_done   (fr_done),
    .fr_line   (fr_line),
    .line_wr   (line_wr),
    .line_addr (line_addr),
    .line_data (line_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fr_rd) frd_cnt <= frd_cnt + 1;
    if (line_wr) lw_cnt <= lw_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    bit          r0;
    bit          r1;
    logic [23:0] a0;
    logic [23:0] a1;
    logic [23:0] ea;
    bit          e0;
    bit          e1;
    int          lat;
  } vec_t;

  vec_t v[8];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkline(input int i);
    logic [31:0] w;
    w = 32'h1234_0000 + 32'(i) * 32'h0101_0101;
    return {w, ~w, w ^ 32'hFFFF_0000, w + 32'd7};
  endfunction

  task automatic wait_rd(input logic [23:0] ea);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (fr_rd) seen = 1'b1;
    end
    chk("fr_rd_seen", 128'(seen), 128'd1);
    chk("fr_addr", 128'(fr_addr), 128'(ea));
    chk("busy_issue", 128'(busy), 128'd1);
    exp_frd++;
  endtask

  task automatic reply(input int lat,
                       input logic [127:0] ln);
    repeat (lat) @(posedge clk);
    #1;
    fr_done = 1'b1;
    fr_line = ln;
    @(posedge clk); #1;
    fr_done = 1'b0;
    fr_line = '0;
  endtask

  task automatic ack_chk(input logic [23:0] ea,
                         input bit e0,
                         input bit e1,
                         input logic [127:0] ln);
    chk("line_wr", 128'(line_wr), 128'd1);
    chk("ack0", 128'(ack0), 128'(e0));
    chk("ack1", 128'(ack1), 128'(e1));
    chk("line_addr", 128'(line_addr), 128'(ea));
    chk("line_data", line_data, ln);
    exp_lw++;
    @(negedge clk);
    if (e0) req0 = 1'b0;
    if (e1) req1 = 1'b0;
  endtask

  initial begin
    logic [127:0] ln;
    req0 = 1'b0;
    req1 = 1'b0;
    addr0 = '0;
    addr1 = '0;
    fr_done = 1'b0;
    fr_line = '0;

    v[0] = '{1, 1, 24'h000100, 24'h004200,
             24'h000100, 1, 0, 5};
    v[1] = '{0, 0, 24'h000000, 24'h000000,
             24'h004200, 0, 1, 6};
    v[2] = '{1, 0, 24'h012345, 24'h000000,
             24'h012340, 1, 0, 40};
    v[3] = '{1, 1, 24'h000100, 24'h004200,
             24'h004200, 0, 1, 4};
    v[4] = '{0, 0, 24'h000000, 24'h000000,
             24'h000100, 1, 0, 3};
    v[5] = '{1, 1, 24'h00A008, 24'h00A00C,
             24'h00A000, 1, 1, 8};
    v[6] = '{1, 1, 24'h000100, 24'h004200,
             24'h000100, 1, 0, 2};
    v[7] = '{0, 0, 24'h000000, 24'h000000,
             24'h004200, 0, 1, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_fr_rd", 128'(fr_rd), 128'd0);
    chk("rst_ack0", 128'(ack0), 128'd0);
    chk("rst_ack1", 128'(ack1), 128'd0);
    chk("rst_line_wr", 128'(line_wr), 128'd0);
    chk("rst_fr_addr", 128'(fr_addr), 128'd0);
    chk("rst_line_addr", 128'(line_addr), 128'd0);
    chk("rst_line_data", line_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk); #1;
    fr_done = 1'b1;
    fr_line = mkline(99);
    @(posedge clk); #1;
    fr_done = 1'b0;
    fr_line = '0;
    chk("stray_done_lw", 128'(line_wr), 128'd0);
    chk("stray_done_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    chk("stray_done_lw2", 128'(line_wr), 128'd0);
    chk("stray_done_data", line_data, 128'd0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (v[i].r0) begin
        req0 = 1'b1;
        addr0 = v[i].a0;
      end
      if (v[i].r1) begin
        req1 = 1'b1;
        addr1 = v[i].a1;
      end
      ln = mkline(i);
      wait_rd(v[i].ea);
      reply(v[i].lat, ln);
      ack_chk(v[i].ea, v[i].e0, v[i].e1, ln);
    end

    req0 = 1'b1;
    addr0 = 24'h020000;
    wait_rd(24'h020000);
    repeat (3) @(posedge clk);
    #1;
    req1 = 1'b1;
    addr1 = 24'h030004;
    ln = mkline(20);
    reply(12, ln);
    ack_chk(24'h020000, 1, 0, ln);
    @(posedge clk); #1;
    chk("late_gap_rd", 128'(fr_rd), 128'd0);
    chk("late_gap_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    chk("late_rd", 128'(fr_rd), 128'd1);
    chk("late_fr_addr", 128'(fr_addr), 128'h030000);
    exp_frd++;
    ln = mkline(21);
    reply(9, ln);
    ack_chk(24'h030000, 0, 1, ln);

    req0 = 1'b1;
    addr0 = 24'h040000;
    wait_rd(24'h040000);
    repeat (4) @(posedge clk);
    #1;
    req0 = 1'b0;
    ln = mkline(30);
    reply(10, ln);
    ack_chk(24'h040000, 0, 0, ln);
    @(posedge clk); #1;
    chk("drop_busy", 128'(busy), 128'd0);
    chk("drop_ack0", 128'(ack0), 128'd0);
    chk("drop_fr_rd", 128'(fr_rd), 128'd0);
    @(negedge clk);

    req0 = 1'b1;
    addr0 = 24'h050000;
    wait_rd(24'h050000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_fr_rd", 128'(fr_rd), 128'd0);
    chk("mid_rst_ack0", 128'(ack0), 128'd0);
    chk("mid_rst_ack1", 128'(ack1), 128'd0);
    chk("mid_rst_lw", 128'(line_wr), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 128'(busy), 128'd0);
    chk("post_rst_ack0", 128'(ack0), 128'd0);
    @(negedge clk);
    req0 = 1'b1;
    addr0 = 24'h060018;
    req1 = 1'b1;
    addr1 = 24'h070000;
    wait_rd(24'h060010);
    ln = mkline(40);
    reply(6, ln);
    ack_chk(24'h060010, 1, 0, ln);
    wait_rd(24'h070000);
    ln = mkline(41);
    reply(6, ln);
    ack_chk(24'h070000, 0, 1, ln);

    repeat (3) @(posedge clk);
    #1;
    chk("fr_rd_count", 128'(frd_cnt), 128'(exp_frd));
    chk("line_wr_count", 128'(lw_cnt), 128'(exp_lw));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
